// File: rtl/ahb_sram_subordinate.sv
// AHB subordinate in front of a word-organised register-file memory with byte-lane writes.
// Define AHB_SRAM_SUB_WAIT_STATES_EN to insert WAIT_STATES wait cycles per legal data phase.
module ahb_sram_subordinate #(
    parameter int DATA_WDT    = 32,
    parameter int MEM_DEPTH   = 256,
    parameter int WAIT_STATES = 2
) (
    input  logic                i_hclk,
    input  logic                i_hreset,
    input  logic                i_hsel,
    input  logic [31:0]         i_haddr,
    input  logic [1:0]          i_htrans,
    input  logic                i_hwrite,
    input  logic [2:0]          i_hsize,
    input  logic [2:0]          i_hburst,
    input  logic [DATA_WDT-1:0] i_hwdata,
    input  logic                i_hready,
    output logic [DATA_WDT-1:0] o_hrdata,
    output logic                o_hreadyout,
    output logic [1:0]          o_hresp
);

    localparam int BYTES  = DATA_WDT / 8;
    localparam int OFF_W  = $clog2(BYTES);
    localparam int IDX_W  = $clog2(MEM_DEPTH);
    localparam int ADDR_W = IDX_W + OFF_W;
    localparam logic [32:0] MEM_BYTES = 33'(MEM_DEPTH * BYTES);

`ifdef AHB_SRAM_SUB_WAIT_STATES_EN
    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ERR1, ST_ERR2} state_t;
`else
    typedef enum logic [1:0] {ST_IDLE, ST_ERR1 = 2'd2, ST_ERR2 = 2'd3} state_t;
`endif

    state_t              state;
    state_t              next_state;
    logic                accept;
    logic                legal;
    logic [31:0]         align_mask;
    logic                dp_valid;
    logic                dp_legal;
    logic                dp_write;
    logic [2:0]          dp_size;
    logic [ADDR_W-1:0]   dp_addr;
    logic [IDX_W-1:0]    dp_idx;
    logic [BYTES-1:0]    byte_en;
    logic                wr_commit;
    int                  lane_lo;
    int                  lane_cnt;
    logic [DATA_WDT-1:0] mem [MEM_DEPTH];

`ifdef AHB_SRAM_SUB_WAIT_STATES_EN
    logic [3:0] wait_cnt;
    logic [3:0] next_cnt;
    logic       unused_bits;
    assign unused_bits = ^{i_hburst, i_htrans[0]};
`else
    logic       unused_bits;
    assign unused_bits = ^{i_hburst, i_htrans[0], 4'(WAIT_STATES)};
`endif

    assign accept     = i_hsel & i_hready & i_htrans[1];
    assign align_mask = (32'd1 << i_hsize) - 32'd1;
    assign legal      = ({1'b0, i_haddr} < MEM_BYTES) && (i_hsize <= 3'(OFF_W))
                        && ((i_haddr & align_mask) == 32'd0);

    assign o_hreadyout = (state == ST_IDLE) || (state == ST_ERR2);
    assign o_hresp     = ((state == ST_ERR1) || (state == ST_ERR2)) ? 2'b01 : 2'b00;

    assign dp_idx    = dp_addr[ADDR_W-1:OFF_W];
    assign o_hrdata  = (dp_valid && dp_legal && !dp_write) ? mem[dp_idx] : '0;
    assign wr_commit = o_hreadyout && dp_valid && dp_legal && dp_write && !i_hreset;

    // Data-phase registers only advance when the current data phase completes.
    always_ff @(posedge i_hclk) begin
        if (i_hreset) begin
            state    <= ST_IDLE;
            dp_valid <= 1'b0;
            dp_legal <= 1'b0;
            dp_write <= 1'b0;
            dp_size  <= '0;
            dp_addr  <= '0;
        end else begin
            state <= next_state;
            if (o_hreadyout) begin
                dp_valid <= accept;
                dp_legal <= accept & legal;
                dp_write <= i_hwrite;
                dp_size  <= i_hsize;
                dp_addr  <= i_haddr[ADDR_W-1:0];
            end
        end
    end

`ifdef AHB_SRAM_SUB_WAIT_STATES_EN
    always_ff @(posedge i_hclk) begin
        if (i_hreset) begin
            wait_cnt <= '0;
        end else begin
            wait_cnt <= next_cnt;
        end
    end
`endif

    // ERR2 completes like IDLE, so a new accept there is handled identically.
    always_comb begin
        next_state = state;
`ifdef AHB_SRAM_SUB_WAIT_STATES_EN
        next_cnt = wait_cnt;
`endif
        case (state)
            ST_IDLE, ST_ERR2: begin
                next_state = ST_IDLE;
                if (accept && !legal) begin
                    next_state = ST_ERR1;
                end
`ifdef AHB_SRAM_SUB_WAIT_STATES_EN
                else if (accept && (WAIT_STATES > 0)) begin
                    next_state = ST_WAIT;
                    next_cnt   = 4'(WAIT_STATES - 1);
                end
`endif
            end
`ifdef AHB_SRAM_SUB_WAIT_STATES_EN
            ST_WAIT: begin
                if (wait_cnt == 4'd0) begin
                    next_state = ST_IDLE;
                end else begin
                    next_cnt = wait_cnt - 4'd1;
                end
            end
`endif
            ST_ERR1: next_state = ST_ERR2;
            default: next_state = ST_IDLE;
        endcase
    end

    assign lane_lo  = int'(dp_addr[OFF_W-1:0]);
    assign lane_cnt = 1 << dp_size;

    always_comb begin
        byte_en = '0;
        for (int n = 0; n < BYTES; n++) begin
            if ((n >= lane_lo) && (n < lane_lo + lane_cnt)) begin
                byte_en[n] = 1'b1;
            end
        end
    end

    always_ff @(posedge i_hclk) begin
        if (wr_commit) begin
            for (int n = 0; n < BYTES; n++) begin
                if (byte_en[n]) begin
                    mem[dp_idx][8*n +: 8] <= i_hwdata[8*n +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_ahb_sram_subordinate.sv
// Self-checking bench for ahb_sram_subordinate against a byte-array reference model.
// Adapts expected wait cycles to AHB_SRAM_SUB_WAIT_STATES_EN.
module tb_ahb_sram_subordinate;

    localparam int DATA_WDT    = 32;
    localparam int MEM_DEPTH   = 256;
    localparam int WAIT_STATES = 2;
    localparam int MEM_BYTES   = MEM_DEPTH * DATA_WDT / 8;
`ifdef AHB_SRAM_SUB_WAIT_STATES_EN
    localparam int EXP_WAITS = WAIT_STATES;
`else
    localparam int EXP_WAITS = 0;
`endif

    logic        clk = 1'b0;
    logic        hreset;
    logic        hsel;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [31:0] hwdata;
    logic        hready;
    logic        other_hready;
    logic [31:0] hrdata;
    logic        hreadyout;
    logic [1:0]  hresp;

    assign hready = hreadyout & other_hready;

    ahb_sram_subordinate #(
        .DATA_WDT(DATA_WDT), .MEM_DEPTH(MEM_DEPTH), .WAIT_STATES(WAIT_STATES)
    ) dut (
        .i_hclk(clk), .i_hreset(hreset), .i_hsel(hsel), .i_haddr(haddr),
        .i_htrans(htrans), .i_hwrite(hwrite), .i_hsize(hsize), .i_hburst(hburst),
        .i_hwdata(hwdata), .i_hready(hready), .o_hrdata(hrdata),
        .o_hreadyout(hreadyout), .o_hresp(hresp)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic        write;
        logic [2:0]  size;
        logic [31:0] wdata;
        logic [1:0]  trans;
        logic        sel;
        logic        blocked;
        logic [2:0]  burst;
    } xfer_t;

    typedef struct {
        int          waits;
        int          err_cycles;
        logic [31:0] rdata;
    } obs_t;

    xfer_t      items[$];
    obs_t       obs[$];
    int         total_cycles;
    int         checks   = 0;
    int         failures = 0;
    logic [7:0] ref_mem [MEM_BYTES];

    function automatic xfer_t mk(input logic [31:0] addr, input logic write, input logic [2:0] size,
                                 input logic [31:0] wdata, input logic [1:0] trans, input logic sel,
                                 input logic blocked, input logic [2:0] burst);
        xfer_t t;
        t.addr = addr; t.write = write; t.size = size; t.wdata = wdata;
        t.trans = trans; t.sel = sel; t.blocked = blocked; t.burst = burst;
        return t;
    endfunction

    // Reference model: per-transfer expected not-ready cycles, ERROR cycles and final read data.
    function automatic void model_step(input xfer_t t, output int ew, output int eerr,
                                       output logic [31:0] erd);
        int unsigned a;
        int unsigned nb;
        int unsigned b;
        ew = 0; eerr = 0; erd = '0;
        if (!(t.sel && t.trans[1] && !t.blocked)) return;
        a  = t.addr;
        nb = 32'd1 << t.size;
        if (a >= MEM_BYTES || t.size > 3'd2 || (a % nb) != 0) begin
            ew = 1; eerr = 2;
            return;
        end
        ew = EXP_WAITS;
        if (t.write) begin
            for (int unsigned i = 0; i < nb; i++) ref_mem[a+i] = t.wdata[8*((a+i)%4) +: 8];
        end else begin
            b   = a - (a % 4);
            erd = {ref_mem[b+3], ref_mem[b+2], ref_mem[b+1], ref_mem[b]};
        end
    endfunction

    task automatic print_summary();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    endtask

    // Pipelined bus driver: the next address is presented in the cycle the current data phase completes.
    task automatic run_items();
        xfer_t       dp;
        bit          dp_valid = 1'b0;
        int          nwait = 0;
        int          nerr = 0;
        int          stall = 0;
        int          qi = 0;
        logic        r;
        obs_t        o;
        total_cycles = 0;
        obs.delete();
        while (qi < items.size() || dp_valid) begin
            @(negedge clk);
            if (dp_valid) hwdata = dp.wdata;
            other_hready = 1'b1;
            r = hreadyout;
            if (dp_valid) begin
                total_cycles++;
                if (r !== 1'b1) nwait++;
                if (hresp !== 2'b00) nerr++;
            end
            if (r !== 1'b1) begin
                stall++;
                if (stall > 64) begin
                    checks++; failures++;
                    $display("[TB] FAIL stall_timeout hreadyout=%b required 1 within 64 cycles", r);
                    print_summary();
                    $finish;
                end
            end else begin
                stall = 0;
                if (dp_valid) begin
                    o.waits = nwait; o.err_cycles = nerr; o.rdata = hrdata;
                    obs.push_back(o);
                end
                if (qi < items.size()) begin
                    dp = items[qi]; qi++; dp_valid = 1'b1; nwait = 0; nerr = 0;
                    hsel = dp.sel; haddr = dp.addr; hwrite = dp.write; hsize = dp.size;
                    htrans = dp.trans; hburst = dp.burst; other_hready = !dp.blocked;
                end else begin
                    dp_valid = 1'b0; hsel = 1'b0; htrans = 2'b00;
                end
            end
        end
        hsel = 1'b0; htrans = 2'b00;
    endtask

    task automatic test_reset();
        hreset = 1'b1; hsel = 1'b0; haddr = '0; htrans = 2'b00; hwrite = 1'b0;
        hsize = 3'd2; hburst = 3'd0; hwdata = '0; other_hready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks += 3;
        if (hreadyout !== 1'b1) begin failures++; $display("[TB] FAIL reset_hreadyout got=%b exp=1", hreadyout); end
        if (hresp !== 2'b00) begin failures++; $display("[TB] FAIL reset_hresp got=%0d exp=0", hresp); end
        if (hrdata !== 32'h0) begin failures++; $display("[TB] FAIL reset_hrdata got=%h exp=0", hrdata); end
        hreset = 1'b0;
    endtask

    task automatic test_fill();
        int ew, eerr; logic [31:0] erd;
        items.delete();
        for (int w = 0; w < MEM_DEPTH; w++) items.push_back(mk(32'(w*4), 1'b1, 3'd2, $urandom, 2'b10, 1'b1, 1'b0, 3'd0));
        run_items();
        for (int i = 0; i < items.size(); i++) begin
            model_step(items[i], ew, eerr, erd);
            checks += 3;
            if (obs[i].waits != ew) begin failures++; $display("[TB] FAIL fill[%0d].waits got=%0d exp=%0d", i, obs[i].waits, ew); end
            if (obs[i].err_cycles != eerr) begin failures++; $display("[TB] FAIL fill[%0d].err got=%0d exp=%0d", i, obs[i].err_cycles, eerr); end
            if (obs[i].rdata !== erd) begin failures++; $display("[TB] FAIL fill[%0d].rdata got=%h exp=%h", i, obs[i].rdata, erd); end
        end
    endtask

    task automatic test_write_read_lanes();
        int ew, eerr; logic [31:0] erd;
        items.delete();
        items.push_back(mk(32'h10, 1'b1, 3'd2, 32'hDEADBEEF, 2'b10, 1'b1, 1'b0, 3'd0));
        items.push_back(mk(32'h10, 1'b0, 3'd2, 32'h0,        2'b10, 1'b1, 1'b0, 3'd0));
        items.push_back(mk(32'h10, 1'b1, 3'd2, 32'h11223344, 2'b10, 1'b1, 1'b0, 3'd0));
        items.push_back(mk(32'h13, 1'b1, 3'd0, 32'hAA000000, 2'b10, 1'b1, 1'b0, 3'd0));
        items.push_back(mk(32'h10, 1'b0, 3'd2, 32'h0,        2'b10, 1'b1, 1'b0, 3'd0));
        items.push_back(mk(32'h10, 1'b1, 3'd1, 32'h00005566, 2'b10, 1'b1, 1'b0, 3'd0));
        items.push_back(mk(32'h10, 1'b0, 3'd2, 32'h0,        2'b10, 1'b1, 1'b0, 3'd0));
        run_items();
        for (int i = 0; i < items.size(); i++) begin
            model_step(items[i], ew, eerr, erd);
            checks += 3;
            if (obs[i].waits != ew) begin failures++; $display("[TB] FAIL lanes[%0d].waits got=%0d exp=%0d", i, obs[i].waits, ew); end
            if (obs[i].err_cycles != eerr) begin failures++; $display("[TB] FAIL lanes[%0d].err got=%0d exp=%0d", i, obs[i].err_cycles, eerr); end
            if (obs[i].rdata !== erd) begin failures++; $display("[TB] FAIL lanes[%0d].rdata got=%h exp=%h", i, obs[i].rdata, erd); end
        end
        checks += 3;
        if (obs[1].rdata !== 32'hDEADBEEF) begin failures++; $display("[TB] FAIL word_read got=%h exp=deadbeef", obs[1].rdata); end
        if (obs[4].rdata !== 32'hAA223344) begin failures++; $display("[TB] FAIL byte_lane got=%h exp=aa223344", obs[4].rdata); end
        if (obs[6].rdata !== 32'hAA225566) begin failures++; $display("[TB] FAIL half_lane got=%h exp=aa225566", obs[6].rdata); end
    endtask

    task automatic test_wait_burst();
        int ew, eerr; logic [31:0] erd;
        items.delete();
        for (int b = 0; b < 4; b++) items.push_back(mk(32'(b*4), 1'b0, 3'd2, 32'h0, (b == 0) ? 2'b10 : 2'b11, 1'b1, 1'b0, 3'd3));
        run_items();
        for (int i = 0; i < items.size(); i++) begin
            model_step(items[i], ew, eerr, erd);
            checks += 3;
            if (obs[i].waits != ew) begin failures++; $display("[TB] FAIL burst[%0d].waits got=%0d exp=%0d", i, obs[i].waits, ew); end
            if (obs[i].err_cycles != eerr) begin failures++; $display("[TB] FAIL burst[%0d].err got=%0d exp=%0d", i, obs[i].err_cycles, eerr); end
            if (obs[i].rdata !== erd) begin failures++; $display("[TB] FAIL burst[%0d].rdata got=%h exp=%h", i, obs[i].rdata, erd); end
        end
        checks++;
        if (total_cycles != 4 * (EXP_WAITS + 1)) begin
            failures++; $display("[TB] FAIL burst_cycles got=%0d exp=%0d", total_cycles, 4 * (EXP_WAITS + 1));
        end
    endtask

    task automatic test_errors_busy_idle();
        int ew, eerr; logic [31:0] erd;
        items.delete();
        items.push_back(mk(32'h400, 1'b0, 3'd2, 32'h0,        2'b10, 1'b1, 1'b0, 3'd0));
        items.push_back(mk(32'h2,   1'b1, 3'd2, 32'h12345678, 2'b10, 1'b1, 1'b0, 3'd0));
        items.push_back(mk(32'h8,   1'b0, 3'd3, 32'h0,        2'b10, 1'b1, 1'b0, 3'd0));
        items.push_back(mk(32'h0,   1'b0, 3'd2, 32'h0,        2'b10, 1'b1, 1'b0, 3'd0));
        items.push_back(mk(32'h40,  1'b0, 3'd2, 32'h0,        2'b10, 1'b1, 1'b0, 3'd1));
        items.push_back(mk(32'h44,  1'b0, 3'd2, 32'h0,        2'b01, 1'b1, 1'b0, 3'd1));
        items.push_back(mk(32'h44,  1'b0, 3'd2, 32'h0,        2'b11, 1'b1, 1'b0, 3'd1));
        items.push_back(mk(32'h48,  1'b1, 3'd2, 32'h5A5A5A5A, 2'b10, 1'b0, 1'b0, 3'd0));
        items.push_back(mk(32'h4C,  1'b1, 3'd2, 32'hA5A5A5A5, 2'b10, 1'b1, 1'b1, 3'd0));
        items.push_back(mk(32'h48,  1'b1, 3'd2, 32'h77777777, 2'b00, 1'b1, 1'b0, 3'd0));
        items.push_back(mk(32'h48,  1'b0, 3'd2, 32'h0,        2'b10, 1'b1, 1'b0, 3'd0));
        items.push_back(mk(32'h4C,  1'b0, 3'd2, 32'h0,        2'b10, 1'b1, 1'b0, 3'd0));
        run_items();
        for (int i = 0; i < items.size(); i++) begin
            model_step(items[i], ew, eerr, erd);
            checks += 3;
            if (obs[i].waits != ew) begin failures++; $display("[TB] FAIL errbusy[%0d].waits got=%0d exp=%0d", i, obs[i].waits, ew); end
            if (obs[i].err_cycles != eerr) begin failures++; $display("[TB] FAIL errbusy[%0d].err got=%0d exp=%0d", i, obs[i].err_cycles, eerr); end
            if (obs[i].rdata !== erd) begin failures++; $display("[TB] FAIL errbusy[%0d].rdata got=%h exp=%h", i, obs[i].rdata, erd); end
        end
    endtask

    task automatic test_back_to_back();
        int ew, eerr; logic [31:0] erd;
        xfer_t t;
        int k;
        items.delete();
        for (int n = 0; n < 200; n++) begin
            t.size = 3'($urandom_range(0, 2));
            t.addr = 32'($urandom_range(0, MEM_BYTES - 1)) & ~((32'd1 << t.size) - 32'd1);
            if ($urandom_range(0, 9) < 2) begin
                t.addr = 32'($urandom_range(0, 2 * MEM_BYTES - 1));
                t.size = 3'($urandom_range(0, 3));
            end
            t.write   = 1'($urandom_range(0, 1));
            t.wdata   = $urandom;
            k         = int'($urandom_range(0, 9));
            t.trans   = (k == 0) ? 2'b00 : (k == 1) ? 2'b01 : {1'b1, 1'(k)};
            t.sel     = ($urandom_range(0, 15) != 0);
            t.blocked = ($urandom_range(0, 15) == 0);
            t.burst   = 3'($urandom_range(0, 7));
            items.push_back(t);
        end
        run_items();
        for (int i = 0; i < items.size(); i++) begin
            model_step(items[i], ew, eerr, erd);
            checks += 3;
            if (obs[i].waits != ew) begin failures++; $display("[TB] FAIL rand[%0d].waits got=%0d exp=%0d", i, obs[i].waits, ew); end
            if (obs[i].err_cycles != eerr) begin failures++; $display("[TB] FAIL rand[%0d].err got=%0d exp=%0d", i, obs[i].err_cycles, eerr); end
            if (obs[i].rdata !== erd) begin failures++; $display("[TB] FAIL rand[%0d].rdata got=%h exp=%h", i, obs[i].rdata, erd); end
        end
    endtask

    task automatic test_reset_mid_write();
        int ew, eerr; logic [31:0] erd;
        @(negedge clk);
        hsel = 1'b1; haddr = 32'h20; hwrite = 1'b1; hsize = 3'd2; htrans = 2'b10; hburst = 3'd0;
        other_hready = 1'b1;
        @(negedge clk);
        hwdata = ~{ref_mem[35], ref_mem[34], ref_mem[33], ref_mem[32]};
        hreset = 1'b1; hsel = 1'b0; htrans = 2'b00;
        @(negedge clk);
        checks += 3;
        if (hreadyout !== 1'b1) begin failures++; $display("[TB] FAIL rstmid_hreadyout got=%b exp=1", hreadyout); end
        if (hresp !== 2'b00) begin failures++; $display("[TB] FAIL rstmid_hresp got=%0d exp=0", hresp); end
        if (hrdata !== 32'h0) begin failures++; $display("[TB] FAIL rstmid_hrdata got=%h exp=0", hrdata); end
        hreset = 1'b0;
        items.delete();
        items.push_back(mk(32'h20, 1'b0, 3'd2, 32'h0, 2'b10, 1'b1, 1'b0, 3'd0));
        run_items();
        model_step(items[0], ew, eerr, erd);
        checks += 2;
        if (obs[0].waits != ew) begin failures++; $display("[TB] FAIL rstmid_read.waits got=%0d exp=%0d", obs[0].waits, ew); end
        if (obs[0].rdata !== erd) begin failures++; $display("[TB] FAIL rstmid_read.rdata got=%h exp=%h", obs[0].rdata, erd); end
    endtask

    initial begin
        #500000;
        checks++; failures++;
        $display("[TB] FAIL global_timeout simulation did not complete within 50000 cycles");
        print_summary();
        $finish;
    end

    initial begin
        test_reset();
        test_fill();
        test_write_read_lanes();
        test_wait_burst();
        test_errors_busy_idle();
        test_back_to_back();
        test_reset_mid_write();
        print_summary();
        $finish;
    end

endmodule

// File: doc/ahb_sram_subordinate.md
# ahb_sram_subordinate

Synthesizable AHB subordinate that fronts a single-port, word-organised register-file memory and answers transfers issued by `ahb_manager`. It sits on the bus opposite the manager and replaces the behavioural subordinate used in simulation. It provides:
- byte, halfword and word writes with little-endian lane selection;
- optional programmable wait states;
- a two-cycle ERROR response for illegal accesses.

## Interface
Parameters:
- `DATA_WDT`, 32, bus data width in bits; allowed values are 32 and 64.
- `MEM_DEPTH`, 256, number of `DATA_WDT`-wide words; must be a power of 2.
- `WAIT_STATES`, 2, number of wait cycles inserted per data phase when the macro is enabled; range 0–15.

Ports:
- `i_hclk`  in  1  bus clock; the block has one clock.
- `i_hreset`  in  1  reset, synchronous and active-high.
- `i_hsel`  in  1  subordinate select.
- `i_haddr`  in  32  byte address; 0 is the first memory byte.
- `i_htrans`  in  2  0 = IDLE, 1 = BUSY, 2 = NONSEQ, 3 = SEQ.
- `i_hwrite`  in  1  1 = write.
- `i_hsize`  in  3  0 = 8 bit, 1 = 16 bit, 2 = 32 bit, 3 = 64 bit.
- `i_hburst`  in  3  burst type; carried for protocol completeness, does not affect behaviour.
- `i_hwdata`  in  `DATA_WDT`  write data, valid in the data phase.
- `i_hready`  in  1  bus-level HREADY, i.e. the previous transfer has completed.
- `o_hrdata`  out  `DATA_WDT`  read data.
- `o_hreadyout`  out  1  this subordinate's HREADY.
- `o_hresp`  out  2  0 = OKAY, 1 = ERROR; the block never drives SPLIT or RETRY.

## Operation
**Accept condition.** An address phase is accepted when `i_hsel & i_hready & i_htrans[1]` is true.
- On accept, the block registers the address, `i_hwrite`, `i_hsize` and a legality flag into the data-phase registers.
- If the accept condition is false, the data-phase registers mark "no transfer".

**Illegal access.** An access is illegal if any of the following holds:
- `i_haddr >= MEM_DEPTH*DATA_WDT/8`;
- `i_hsize > log2(DATA_WDT/8)`;
- `i_haddr` is not aligned to `i_hsize`.

**State machine**, states IDLE, WAIT, ERR1, ERR2:
- IDLE → WAIT on accept, when the access is legal and the wait count is greater than 0.
- IDLE → ERR1 on accept, when the access is illegal.
- IDLE → IDLE on accept, when the access is legal and the wait count is 0; the transfer completes zero-wait.
- WAIT: a counter loads `WAIT_STATES-1` and decrements each cycle. At 0, the block returns to IDLE with `o_hreadyout=1` for one completing cycle.
- ERR1 → ERR2 unconditionally.
- ERR2 → IDLE; a new accept in this cycle is processed as if taken from IDLE.

**Outputs by phase:**
- IDLE, BUSY or unselected data phases: `o_hreadyout=1`, `o_hresp=OKAY`.
- WAIT: `o_hreadyout=0`, `o_hresp=OKAY`.
- ERR1: `o_hreadyout=0`, `o_hresp=ERROR`.
- ERR2: `o_hreadyout=1`, `o_hresp=ERROR`.

**Writes.**
- The memory word index is `addr[log2(MEM_DEPTH)+log2(DATA_WDT/8)-1 : log2(DATA_WDT/8)]`.
- Byte enables come from `hsize` and the low address bits: lane n maps to bits `[8n+7:8n]`.
- The write commits on the edge that ends the write data phase, i.e. when `o_hreadyout=1` in that phase.
- An ERROR transfer never writes.

**Reads.**
- `o_hrdata` is the full word at the data-phase index, read combinationally from the array.
- A read that immediately follows a write to the same word returns the newly written bytes, because the write has already committed.
- `o_hrdata` is 0 in any cycle that is not a legal read data phase.
- The block does not replicate lanes on reads.

**Reset.** Reset mid-transfer abandons the transfer: no write occurs and the state goes to IDLE. Memory contents are not reset.

## Timing
- Reset values: `o_hreadyout=1`, `o_hresp=OKAY`, `o_hrdata=0`, state IDLE, wait counter 0, data-phase registers = "no transfer".
- Zero-wait legal transfer: address phase in cycle N; data phase completes in cycle N+1. Read data is valid in N+1.
- With wait count W: data phase spans cycles N+1 … N+1+W; `o_hreadyout=0` for W cycles and 1 in the last cycle.
- Error: ERROR is driven in N+1 with `o_hreadyout=0`, and in N+2 with `o_hreadyout=1`.
- Pipelining: back-to-back accepts are legal whenever `o_hreadyout=1`. The next address phase overlaps the completing data phase.
- `i_hready=0` caused by another subordinate blocks accept; it does not disturb this block's idle outputs.

## Configuration
- `AHB_SRAM_SUB_WAIT_STATES_EN`
  - Defined: every legal NONSEQ/SEQ data phase inserts `WAIT_STATES` wait cycles.
  - Undefined: the WAIT state and counter are compiled out, and every legal transfer is zero-wait. `WAIT_STATES` is ignored.
  - ERROR behaviour is identical in both builds.

## Test plan
- Zero-wait write then read (macro off): NONSEQ write to 0x10 with 0xDEADBEEF, then NONSEQ read of 0x10 → `o_hrdata=0xDEADBEEF` one cycle after the read address phase, `o_hresp=OKAY`, `o_hreadyout` always 1.
- Byte lanes: byte write 0xAA to 0x13 over word 0x11223344 → read of 0x10 returns 0xAA223344; halfword write 0x5566 to 0x10 → 0xAA225566.
- Wait states (macro on, `WAIT_STATES=2`): INCR4 read burst from 0x0 → each beat shows `o_hreadyout` 0, 0, 1; 12 data-phase cycles in total; data equals the preloaded values.
- Errors: read of 0x400 (`MEM_DEPTH=256`), then word write to 0x2 → each gives ERROR for two cycles with `o_hreadyout` 0 then 1; memory is unchanged and `o_hrdata=0`.
- BUSY/IDLE and deselect: an INCR burst with a BUSY beat, and a transfer with `i_hsel=0` → OKAY zero-wait response with no memory access.
- Reset mid-wait: assert `i_hreset` during WAIT of a write to 0x20 → next cycle `o_hreadyout=1`, `o_hresp=OKAY`; word 0x20 is unchanged.
